// File: rtl/cpu_debug_scan_pkg.sv
// Shared state codes and virtual IR codes for the CPU debug scan master.
package cpu_debug_scan_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_UIR  = 3'd1;
    localparam logic [2:0] ST_CDR  = 3'd2;
    localparam logic [2:0] ST_SDR  = 3'd3;
    localparam logic [2:0] ST_E1DR = 3'd4;
    localparam logic [2:0] ST_RTI  = 3'd5;

    typedef logic [2:0] scan_state_t;

    localparam logic [1:0] IR_OCIMEM    = 2'd0;
    localparam logic [1:0] IR_TRACEMEM  = 2'd1;
    localparam logic [1:0] IR_BREAK     = 2'd2;
    localparam logic [1:0] IR_TRACECTRL = 2'd3;

endpackage

// File: rtl/cpu_debug_scan_tck_gen.sv
// TCK phase counter: low for TCK_HALF clk cycles, then high for TCK_HALF cycles.
module cpu_debug_scan_tck_gen #(
    parameter int TCK_HALF = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tck,
    output logic rise,
    output logic period_end
);

    localparam int PERIOD = 2 * TCK_HALF;
    localparam int CW     = $clog2(PERIOD);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!en || period_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // rise marks the clk edge on which tck goes high
    assign rise       = en && (cnt == CW'(TCK_HALF - 1));
    assign period_end = en && (cnt == CW'(PERIOD - 1));
    assign tck        = en && (cnt >= CW'(TCK_HALF));

endmodule

// File: rtl/cpu_debug_scan_master.sv
// Virtual-JTAG scan master: UIR, CDR, SDR (DR_WIDTH bits), E1DR, RTI per command.
// Optional IR readback enabled by macro CPU_DEBUG_SCAN_IR_READBACK_EN.
module cpu_debug_scan_master
    import cpu_debug_scan_pkg::*;
#(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_HALF = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_e1dr,
    output logic                vji_rti
);

    localparam int BW = $clog2(DR_WIDTH + 1);

    scan_state_t         state;
    scan_state_t         nxt;
    logic [DR_WIDTH-1:0] shift_reg;
    logic [BW-1:0]       bit_cnt;
    logic                tck_rise;
    logic                tck_end;
    logic                accept;

    assign accept = cmd_valid && cmd_ready;

    cpu_debug_scan_tck_gen #(.TCK_HALF(TCK_HALF)) u_tck_gen (
        .clk       (clk),
        .reset     (reset),
        .en        (state != ST_IDLE),
        .tck       (vji_tck),
        .rise      (tck_rise),
        .period_end(tck_end)
    );

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE: if (accept)  nxt = ST_UIR;
            ST_UIR:  if (tck_end) nxt = ST_CDR;
            ST_CDR:  if (tck_end) nxt = ST_SDR;
            ST_SDR:  if (tck_end && (bit_cnt == BW'(DR_WIDTH - 1))) nxt = ST_E1DR;
            ST_E1DR: if (tck_end) nxt = ST_RTI;
            ST_RTI:  if (tck_end) nxt = ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b0;
            vji_ir_in <= '0;
            vji_tdi   <= 1'b0;
            bit_cnt   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state     <= nxt;
            cmd_ready <= (nxt == ST_IDLE);
            rsp_valid <= (state == ST_E1DR) && tck_end;
            if (accept) vji_ir_in <= cmd_ir;
            if ((state == ST_E1DR) && tck_end) rsp_data <= shift_reg;
            if (state != ST_SDR) bit_cnt <= '0;
            else if (tck_end)    bit_cnt <= bit_cnt + 1'b1;
            // next TDI bit is presented at the start of each SDR period
            if (tck_end) vji_tdi <= (nxt == ST_SDR) ? shift_reg[0] : 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            shift_reg <= cmd_data;
        end else if ((state == ST_SDR) && tck_rise) begin
            shift_reg <= {vji_tdo, shift_reg[DR_WIDTH-1:1]};
        end
    end

`ifdef CPU_DEBUG_SCAN_IR_READBACK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_ir_out <= '0;
        end else if ((state == ST_UIR) && tck_rise) begin
            rsp_ir_out <= vji_ir_out;
        end
    end
`else
    logic unused_ir_out;
    assign unused_ir_out = ^vji_ir_out;
    assign rsp_ir_out    = '0;
`endif

    assign vji_uir  = (state == ST_UIR);
    assign vji_cdr  = (state == ST_CDR);
    assign vji_sdr  = (state == ST_SDR);
    assign vji_e1dr = (state == ST_E1DR);
    assign vji_rti  = (state == ST_IDLE) || (state == ST_RTI);

endmodule

// File: tb/tb_cpu_debug_scan_master.sv
// Directed bench for cpu_debug_scan_master: default instance plus an 8-bit, TCK_HALF=1 instance.
module tb_cpu_debug_scan_master;
    import cpu_debug_scan_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        cmd_valid, cmd_ready, rsp_valid;
    logic [1:0]  cmd_ir, rsp_ir_out, vji_ir_in, vji_ir_out;
    logic [37:0] cmd_data, rsp_data;
    logic        vji_tck, vji_tdi, vji_tdo, vji_uir, vji_cdr, vji_sdr, vji_e1dr, vji_rti;
    int          tdo_mode;
    assign vji_tdo = (tdo_mode == 1) ? 1'b1 : vji_tdi;

    cpu_debug_scan_master dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_ir_out(rsp_ir_out), .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
        .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out), .vji_uir(vji_uir), .vji_cdr(vji_cdr),
        .vji_sdr(vji_sdr), .vji_e1dr(vji_e1dr), .vji_rti(vji_rti)
    );

    logic        cmd_valid8, cmd_ready8, rsp_valid8;
    logic [1:0]  cmd_ir8, rsp_ir_out8, vji_ir_in8, vji_ir_out8;
    logic [7:0]  cmd_data8, rsp_data8;
    logic        vji_tck8, vji_tdi8, vji_tdo8, vji_uir8, vji_cdr8, vji_sdr8, vji_e1dr8, vji_rti8;
    // inverted loopback turns 8'hAA on TDI into an alternating 1,0,1,0 TDO stream
    assign vji_tdo8 = ~vji_tdi8;

    cpu_debug_scan_master #(.DR_WIDTH(8), .IR_WIDTH(2), .TCK_HALF(1)) dut8 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid8), .cmd_ready(cmd_ready8),
        .cmd_ir(cmd_ir8), .cmd_data(cmd_data8), .rsp_valid(rsp_valid8), .rsp_data(rsp_data8),
        .rsp_ir_out(rsp_ir_out8), .vji_tck(vji_tck8), .vji_tdi(vji_tdi8), .vji_tdo(vji_tdo8),
        .vji_ir_in(vji_ir_in8), .vji_ir_out(vji_ir_out8), .vji_uir(vji_uir8), .vji_cdr(vji_cdr8),
        .vji_sdr(vji_sdr8), .vji_e1dr(vji_e1dr8), .vji_rti(vji_rti8)
    );

`ifdef CPU_DEBUG_SCAN_IR_READBACK_EN
    localparam logic [1:0] EXP_IR  = 2'b11;
    localparam logic [1:0] EXP_IR8 = 2'b01;
`else
    localparam logic [1:0] EXP_IR  = 2'b00;
    localparam logic [1:0] EXP_IR8 = 2'b00;
`endif

    int cyc = 0, sdr_cnt = 0, rsp_cnt = 0, tck_hi = 0, uir_cnt = 0, cdr_cnt = 0, e1_cnt = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (vji_sdr)   sdr_cnt <= sdr_cnt + 1;
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
        if (vji_tck)   tck_hi  <= tck_hi + 1;
        if (vji_uir)   uir_cnt <= uir_cnt + 1;
        if (vji_cdr)   cdr_cnt <= cdr_cnt + 1;
        if (vji_e1dr)  e1_cnt  <= e1_cnt + 1;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(output int n);
        n = -1;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready) begin
                n = cyc;
                break;
            end
            @(negedge clk);
        end
        if (n < 0) check("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_rsp(input int n, output int lat);
        lat = -1;
        for (int i = 0; i < 400; i++) begin
            if (rsp_valid) begin
                lat = cyc - n;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_scan(input logic [1:0] ir, input logic [37:0] data, input bit hold,
                           output int n_acc, output int lat);
        @(negedge clk);
        cmd_ir    = ir;
        cmd_data  = data;
        cmd_valid = 1'b1;
        wait_ready(n_acc);
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
        wait_rsp(n_acc, lat);
    endtask

    int n1, n2, lat, s_sdr, s_rsp, s_tck, s_uir, s_cdr, s_e1;

    initial begin
        cmd_valid = 1'b0; cmd_ir = '0; cmd_data = '0; vji_ir_out = 2'b11;
        cmd_valid8 = 1'b0; cmd_ir8 = '0; cmd_data8 = '0; vji_ir_out8 = 2'b01;
        tdo_mode = 0;

        #1 reset = 1'b1;
        #2;
        check("rst_ready", cmd_ready, 0);
        check("rst_tck", vji_tck, 0);
        check("rst_tdi", vji_tdi, 0);
        check("rst_ir_in", vji_ir_in, 0);
        check("rst_ind", {vji_uir, vji_cdr, vji_sdr, vji_e1dr, vji_rti}, 5'b00001);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_ir", rsp_ir_out, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("ready_before_clk", cmd_ready, 0);
        @(negedge clk);
        check("ready_after_rst", cmd_ready, 1);

        // loopback with default parameters
        s_sdr = sdr_cnt; s_tck = tck_hi; s_uir = uir_cnt; s_cdr = cdr_cnt; s_e1 = e1_cnt;
        do_scan(IR_BREAK, 38'h2A_5A5A_A5A5, 1'b0, n1, lat);
        check("lb_latency", lat, 165);
        check("lb_rsp_data", rsp_data, 38'h2A_5A5A_A5A5);
        check("lb_ir_in", vji_ir_in, 2);
        check("lb_rsp_ir", rsp_ir_out, EXP_IR);
        check("lb_rti_ind", {vji_uir, vji_cdr, vji_sdr, vji_e1dr, vji_rti}, 5'b00001);
        check("lb_ready_rti", cmd_ready, 0);
        @(negedge clk);
        check("lb_pulse_len", rsp_valid, 0);
        check("lb_data_hold", rsp_data, 38'h2A_5A5A_A5A5);
        repeat (4) @(negedge clk);
        check("lb_tck_high_cycles", tck_hi - s_tck, 84);
        check("lb_uir_cycles", uir_cnt - s_uir, 4);
        check("lb_cdr_cycles", cdr_cnt - s_cdr, 4);
        check("lb_e1dr_cycles", e1_cnt - s_e1, 4);
        check("lb_sdr_cycles", sdr_cnt - s_sdr, 152);
        check("idle_tck", vji_tck, 0);
        check("idle_ready", cmd_ready, 1);

        // TDO tied high, all-zero data shifted out
        tdo_mode = 1;
        s_sdr = sdr_cnt;
        do_scan(IR_TRACEMEM, 38'h0, 1'b0, n1, lat);
        check("ones_latency", lat, 165);
        check("ones_rsp_data", rsp_data, 38'h3F_FFFF_FFFF);
        check("ones_ir_in", vji_ir_in, 1);
        repeat (5) @(negedge clk);
        check("ones_sdr_cycles", sdr_cnt - s_sdr, 152);
        tdo_mode = 0;

        // cmd_valid held high: one response, next acceptance only after RTI + IDLE
        s_rsp = rsp_cnt;
        do_scan(IR_OCIMEM, 38'h01_2345_6789, 1'b1, n1, lat);
        check("hold_latency", lat, 165);
        check("hold_rsp_data", rsp_data, 38'h01_2345_6789);
        check("hold_ready_rti", cmd_ready, 0);
        cmd_ir   = IR_TRACECTRL;
        cmd_data = 38'h3C_0000_FFFF;
        wait_ready(n2);
        check("hold_accept_gap", n2 - n1, 169);
        check("hold_one_rsp", rsp_cnt - s_rsp, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_rsp(n2, lat);
        check("hold2_latency", lat, 165);
        check("hold2_rsp_data", rsp_data, 38'h3C_0000_FFFF);
        check("hold2_ir_in", vji_ir_in, 3);
        repeat (5) @(negedge clk);
        check("hold2_rsp_count", rsp_cnt - s_rsp, 2);

        // reset in the middle of SDR bit 10
        @(negedge clk);
        cmd_ir = IR_BREAK; cmd_data = 38'h3F_FFFF_FFFF; cmd_valid = 1'b1;
        wait_ready(n1);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (vji_sdr) break;
            @(negedge clk);
        end
        repeat (40) @(negedge clk);
        check("mid_sdr_active", vji_sdr, 1);
        check("mid_tdi_one", vji_tdi, 1);
        s_rsp = rsp_cnt;
        #2 reset = 1'b1;
        #1;
        check("mid_rst_ind", {vji_uir, vji_cdr, vji_sdr, vji_e1dr, vji_rti}, 5'b00001);
        check("mid_rst_tck", vji_tck, 0);
        check("mid_rst_tdi", vji_tdi, 0);
        check("mid_rst_ir_in", vji_ir_in, 0);
        check("mid_rst_ready", cmd_ready, 0);
        check("mid_rst_rsp_data", rsp_data, 0);
        check("mid_rst_rsp_ir", rsp_ir_out, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid_ready_after", cmd_ready, 1);
        repeat (200) @(negedge clk);
        check("mid_no_rsp", rsp_cnt - s_rsp, 0);
        do_scan(IR_TRACEMEM, 38'h15_0F0F_3C3C, 1'b0, n1, lat);
        check("post_rst_latency", lat, 165);
        check("post_rst_rsp_data", rsp_data, 38'h15_0F0F_3C3C);
        repeat (5) @(negedge clk);

        // DR_WIDTH=8, TCK_HALF=1 instance
        @(negedge clk);
        check("w8_ready", cmd_ready8, 1);
        cmd_valid8 = 1'b1; cmd_ir8 = IR_TRACECTRL; cmd_data8 = 8'hAA;
        n1 = cyc;
        @(negedge clk);
        cmd_valid8 = 1'b0;
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            if (rsp_valid8) begin
                lat = cyc - n1;
                break;
            end
            @(negedge clk);
        end
        check("w8_latency", lat, 23);
        check("w8_rsp_data", rsp_data8, 8'h55);
        check("w8_ir_in", vji_ir_in8, 3);
        check("w8_rsp_ir", rsp_ir_out8, EXP_IR8);
        repeat (4) @(negedge clk);
        check("w8_idle_ready", cmd_ready8, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
